// File: rtl/exe_div_unit_pkg.sv
// Shared types for the EXE-stage divider: FSM state encoding, the request
// bundle ID builds from OP_DIV/OP_DIVU, and the default operand width.
package exe_div_unit_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } div_state_e;

    typedef struct packed {
        logic start;
        logic is_signed;
    } div_req_t;

endpackage

// File: rtl/exe_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU (LO=quotient, HI=remainder).
// Signed operands are reduced to unsigned magnitudes, divided over DATA_W
// iterations, then sign-corrected in a single fix-up cycle. div_busy stalls the
// front end while CALC/FIX run; div_done pulses for one cycle with the results.
// Optional build macro: DIV_FAST_ZERO_EN -- a zero dividend or zero divisor
// completes in one cycle without entering CALC/FIX.
module exe_div_unit
    import exe_div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_flush,
    input  logic              div_start,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              div_busy,
    output logic              div_done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dq_q, dq_d;      // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [DATA_W-1:0] rem_q, rem_d;    // partial remainder, always < |divisor|
    logic [DATA_W-1:0] dsr_q, dsr_d;    // |divisor|
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              dbz_q, dbz_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] remr_q, remr_d;

    div_req_t          req;
    logic              accept;
    logic              fast_zero;
    logic              dvd_neg, dsr_neg;
    logic [DATA_W-1:0] dvd_abs, dsr_abs;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              borrow;
    logic              unused_diff_msb;

    assign req = '{start: div_start, is_signed: div_signed};

    // Operand conditioning and the single iteration step of the restoring divide.
    always_comb begin
        dvd_neg = req.is_signed & dividend[DATA_W-1];
        dsr_neg = req.is_signed & divisor[DATA_W-1];
        // -(-2^(W-1)) wraps to 2^(W-1), which is exactly the unsigned magnitude wanted.
        dvd_abs = dvd_neg ? -dividend : dividend;
        dsr_abs = dsr_neg ? -divisor : divisor;
        accept  = req.start & ~div_flush & ((state_q == DIV_IDLE) | (state_q == DIV_DONE));
`ifdef DIV_FAST_ZERO_EN
        fast_zero = (dividend == '0) | (divisor == '0);
`else
        fast_zero = 1'b0;
`endif
        shifted          = {rem_q, dq_q[DATA_W-1]};
        {borrow, diff}   = {1'b0, shifted} - {2'b00, dsr_q};
        // diff[DATA_W] is always zero whenever the subtraction is kept.
        unused_diff_msb  = diff[DATA_W];
    end

    // Next-state logic; flush overrides everything, including a same-cycle start.
    always_comb begin
        state_d = state_q;
        if (div_flush) begin
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE, DIV_DONE: state_d = req.start ? (fast_zero ? DIV_DONE : DIV_CALC) : DIV_IDLE;
                DIV_CALC:           state_d = (cnt_q == CNT_LAST) ? DIV_FIX : DIV_CALC;
                DIV_FIX:            state_d = DIV_DONE;
                default:            state_d = DIV_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        div_busy = (state_q == DIV_CALC) | (state_q == DIV_FIX);
        div_done = (state_q == DIV_DONE);
    end

    // Datapath next values: load on accept, iterate in CALC, sign-fix and publish in FIX.
    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block leaves a value unassigned (no latches).
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        remr_d  = remr_q;
        if (accept) begin
            cnt_d   = '0;
            dq_d    = dvd_abs;
            rem_d   = '0;
            dsr_d   = dsr_abs;
            q_neg_d = dvd_neg ^ dsr_neg;
            r_neg_d = dvd_neg;
            dbz_d   = (divisor == '0);
            if (fast_zero) begin
                // Divisor zero takes priority, so 0/0 matches the slow path result.
                quot_d = (divisor == '0) ? '1 : '0;
                remr_d = dividend;
            end
        end else if (!div_flush && state_q == DIV_CALC) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (borrow) begin
                rem_d = shifted[DATA_W-1:0];
                dq_d  = {dq_q[DATA_W-2:0], 1'b0};
            end else begin
                rem_d = diff[DATA_W-1:0];
                dq_d  = {dq_q[DATA_W-2:0], 1'b1};
            end
        end else if (!div_flush && state_q == DIV_FIX) begin
            // A zero divisor leaves all-ones in dq already; forcing it ignores the sign flip.
            quot_d = dbz_q ? '1 : (q_neg_q ? -dq_q : dq_q);
            remr_d = r_neg_q ? -rem_q : rem_q;
        end
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            remr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            remr_q  <= remr_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = remr_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed testbench for exe_div_unit: reset, unsigned/signed division,
// boundary operands, divide by zero, flush, flush-with-start, back-to-back
// and reset in the middle of an operation.
module tb_exe_div_unit;

    localparam int W        = 32;
    localparam int FULL_LAT = W + 2;
`ifdef DIV_FAST_ZERO_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = FULL_LAT;
`endif

    typedef struct {
        string        name;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         div_flush = 1'b0;
    logic         div_start = 1'b0;
    logic         div_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         div_busy;
    logic         div_done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks = 0;
    int errors = 0;

    exe_div_unit #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_flush  (div_flush),
        .div_start  (div_start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns at the sample point of cycle 1.
    task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        div_start  = 1'b1;
        step();
        div_start  = 1'b0;
    endtask

    // Waits for div_done (bounded); lat is the cycle number of done, 0 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 200; c++) begin
            if (div_done) begin
                lat = c;
                break;
            end
            if (div_busy) busy_cnt++;
            step();
        end
    endtask

    task automatic check_vec(input vec_t v, input logic start_next);
        int lat;
        int busy_cnt;
        start_op(v.sgn, v.a, v.b);
        wait_done(lat, busy_cnt);
        checks++;
        if (lat !== v.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", v.name, lat, v.lat);
        end
        checks++;
        if (busy_cnt !== v.lat - 1) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want %0d", v.name, busy_cnt, v.lat - 1);
        end
        checks++;
        if (quotient !== v.q) begin
            errors++;
            $display("FAIL %s quotient: got %h want %h", v.name, quotient, v.q);
        end
        checks++;
        if (remainder !== v.r) begin
            errors++;
            $display("FAIL %s remainder: got %h want %h", v.name, remainder, v.r);
        end
        if (!start_next) begin
            step();
            checks++;
            if (div_done !== 1'b0 || div_busy !== 1'b0) begin
                errors++;
                $display("FAIL %s done pulse end: got done=%b busy=%b want 0 0", v.name, div_done, div_busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset state: got busy=%b done=%b q=%h r=%h want 0 0 0 0",
                     div_busy, div_done, quotient, remainder);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_divide();
        vec_t v[7];
        v[0] = '{"divu_100_7",    1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        FULL_LAT};
        v[1] = '{"div_m7_2",      1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, FULL_LAT};
        v[2] = '{"div_7_m2",      1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        FULL_LAT};
        v[3] = '{"div_min_m1",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        FULL_LAT};
        v[4] = '{"divu_min_max",  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, FULL_LAT};
        v[5] = '{"divu_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        FULL_LAT};
        v[6] = '{"div_m100_m7",   1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, FULL_LAT};
        foreach (v[i]) check_vec(v[i], 1'b0);
    endtask

    task automatic test_div_zero();
        vec_t v[4];
        v[0] = '{"divu_5_0",  1'b0, 32'd5,        32'd0, 32'hFFFFFFFF, 32'd5,        ZERO_LAT};
        v[1] = '{"div_m5_0",  1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, ZERO_LAT};
        v[2] = '{"div_0_5",   1'b1, 32'd0,        32'd5, 32'd0,        32'd0,        ZERO_LAT};
        v[3] = '{"divu_0_0",  1'b0, 32'd0,        32'd0, 32'hFFFFFFFF, 32'd0,        ZERO_LAT};
        foreach (v[i]) check_vec(v[i], 1'b0);
    endtask

    // Checks that no done appears for n cycles and the outputs stay at old values.
    task automatic expect_quiet(input string name, input int n,
                                input logic [W-1:0] old_q, input logic [W-1:0] old_r);
        int seen = 0;
        for (int c = 0; c < n; c++) begin
            if (div_done || div_busy) seen++;
            step();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL %s quiet: got %0d busy/done cycles want 0", name, seen);
        end
        checks++;
        if (quotient !== old_q || remainder !== old_r) begin
            errors++;
            $display("FAIL %s outputs held: got q=%h r=%h want q=%h r=%h", name, quotient, remainder, old_q, old_r);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] old_q;
        logic [W-1:0] old_r;
        vec_t         nv;
        old_q = quotient;
        old_r = remainder;
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (9) step();
        div_flush = 1'b1;
        step();
        div_flush = 1'b0;
        checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0) begin
            errors++;
            $display("FAIL flush idle: got busy=%b done=%b want 0 0", div_busy, div_done);
        end
        expect_quiet("flush", 40, old_q, old_r);
        nv = '{"after_flush", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, FULL_LAT};
        check_vec(nv, 1'b0);
    endtask

    task automatic test_flush_start();
        logic [W-1:0] old_q;
        logic [W-1:0] old_r;
        old_q      = quotient;
        old_r      = remainder;
        div_flush  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd50;
        divisor    = 32'd0;
        div_start  = 1'b1;
        step();
        div_start  = 1'b0;
        div_flush  = 1'b0;
        expect_quiet("flush_start", 40, old_q, old_r);
    endtask

    task automatic test_back_to_back();
        vec_t a;
        vec_t b;
        a = '{"b2b_first",  1'b0, 32'd100,      32'd7, 32'd14,       32'd2,        FULL_LAT};
        b = '{"b2b_second", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, FULL_LAT};
        check_vec(a, 1'b1);
        check_vec(b, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        vec_t v;
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (19) step();
        rst = 1'b0;
        #1;
        checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset mid-op: got busy=%b done=%b q=%h r=%h want 0 0 0 0",
                     div_busy, div_done, quotient, remainder);
        end
        #1;
        rst = 1'b1;
        step();
        v = '{"after_reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, FULL_LAT};
        check_vec(v, 1'b0);
    endtask

    initial begin
        test_reset();
        test_divide();
        test_div_zero();
        test_flush();
        test_flush_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
